alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, data-path width in bits; all arithmetic and flags SHALL scale with it.
REQ-002 clk  input  1  single rising-edge clock; all state SHALL update only on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 select  input  4  operation code, sampled each rising clk edge.
REQ-005 a  input  WIDTH  operand A, two's complement.
REQ-006 b  input  WIDTH  operand B, two's complement.
REQ-007 out  output  WIDTH  registered result.
REQ-008 Z  output  1  registered zero flag; 1 when out is all zeros.
REQ-009 N  output  1  registered negative flag; equals out[WIDTH-1].

Function
REQ-010 Latency SHALL be one clock: out, Z and N SHALL reflect select/a/b sampled at the previous rising edge; no handshake, a new operation is accepted every cycle.
REQ-011 Opcode map (result R, arithmetic modulo 2^WIDTH):
- 0000 ADD: R = a + b
- 0001 INC: R = a + 1
- 0010 NEG: R = 0 - a
- 0011 SUB: R = a - b
- 0100 PASSA: R = a
- 0101 AND: R = a & b
- 0110 OR: R = a | b
- 0111 XOR: R = a ^ b
- 1000 SLL: R = a << b[4:0]
- 1001 SRL: R = a >> b[4:0], zero fill
- 1010 SRA: R = a >> b[4:0], sign fill
- 1011 PASSB: R = b
- 1100 SLT: R = 1 if signed a < signed b, else 0
- 1101-1111: R = 0.
REQ-012 Carry-out and overflow SHALL be discarded; results wrap silently (0xFFFFFFFF + 1 = 0).
REQ-013 NEG of the most negative value (0x80000000) SHALL yield 0x80000000 with N = 1.
REQ-014 Shift amounts SHALL use only the low log2(WIDTH) bits of b; upper bits of b SHALL be ignored.
REQ-015 Z and N SHALL be computed from the same R registered into out, in the same cycle; they SHALL never be stale relative to out.
REQ-016 Unknown opcodes SHALL produce out = 0, Z = 1, N = 0.

Reset
REQ-017 When rst = 1 at a rising clk edge, out SHALL become 0, Z SHALL become 1 and N SHALL become 0, regardless of select, a and b.
REQ-018 Reset SHALL take priority over any operation in flight; the operation sampled in the reset cycle SHALL be discarded.
REQ-019 In the first edge after rst deasserts, normal operation SHALL resume with the inputs sampled at that edge.

Structure
REQ-020 Opcode constants (4-bit encodings for REQ-011) SHALL reside in a shared package, alu_pkg, used by the ALU and by decode logic elsewhere.
REQ-021 Combinational result generation SHALL be one sub-module, alu_core (select, a, b -> R); alu SHALL wrap it with the output/flag register stage.
REQ-022 The design SHALL contain no latches; every opcode path SHALL assign R.

Verification
REQ-023 a=6, b=5, select=0000 -> out=11, Z=0, N=0 one cycle later; select=0001 -> 7; select=0011 -> 1; select=0100 -> 6.
REQ-024 a=6, select=0010 -> out=0xFFFFFFFA, N=1, Z=0.
REQ-025 a=6, b=6, select=0011 -> out=0, Z=1, N=0.
REQ-026 a=0xFFFFFFFF, select=0001 -> out=0, Z=1; a=0x80000000, select=0010 -> out=0x80000000, N=1.
REQ-027 a=0x80000000, b=0x00000024 (shift 4), select=1010 -> 0xF8000000; select=1001 -> 0x08000000; a=-1, b=0, select=1100 -> 1.
REQ-028 Operation ADD running, assert rst for one edge -> out=0, Z=1, N=0 that cycle; next edge with rst=0 -> ADD result restored.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and helpers, imported by the ALU and by decode logic elsewhere.
package alu_pkg;

    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [SEL_W-1:0] OP_INC   = 4'b0001;
    localparam logic [SEL_W-1:0] OP_NEG   = 4'b0010;
    localparam logic [SEL_W-1:0] OP_SUB   = 4'b0011;
    localparam logic [SEL_W-1:0] OP_PASSA = 4'b0100;
    localparam logic [SEL_W-1:0] OP_AND   = 4'b0101;
    localparam logic [SEL_W-1:0] OP_OR    = 4'b0110;
    localparam logic [SEL_W-1:0] OP_XOR   = 4'b0111;
    localparam logic [SEL_W-1:0] OP_SLL   = 4'b1000;
    localparam logic [SEL_W-1:0] OP_SRL   = 4'b1001;
    localparam logic [SEL_W-1:0] OP_SRA   = 4'b1010;
    localparam logic [SEL_W-1:0] OP_PASSB = 4'b1011;
    localparam logic [SEL_W-1:0] OP_SLT   = 4'b1100;

    // True for encodings that produce a defined, non-forced-zero result.
    function automatic logic op_is_valid(input logic [SEL_W-1:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU result generation: select, a, b -> r.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [SEL_W-1:0] select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_c
);

    localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Only the low log2(WIDTH) bits of b steer the shifter.
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        r_c = '0;
        case (select)
            OP_ADD:   r_c = a + b;
            OP_INC:   r_c = a + WIDTH'(1);
            OP_NEG:   r_c = '0 - a;
            OP_SUB:   r_c = a - b;
            OP_PASSA: r_c = a;
            OP_AND:   r_c = a & b;
            OP_OR:    r_c = a | b;
            OP_XOR:   r_c = a ^ b;
            OP_SLL:   r_c = a << shamt;
            OP_SRL:   r_c = a >> shamt;
            OP_SRA:   r_c = WIDTH'($signed(a) >>> shamt);
            OP_PASSB: r_c = b;
            OP_SLT:   r_c = WIDTH'($signed(a) < $signed(b));
            default:  r_c = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU top: combinational core followed by a single register stage for result and flags.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] select,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             Z,
    output logic             N
);

    logic [WIDTH-1:0] r_c;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .select (select),
        .a      (a),
        .b      (b),
        .r_c    (r_c)
    );

    // Flags derive from the same r_c as out so they can never lag the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            Z   <= 1'b1;
            N   <= 1'b0;
        end else begin
            out <= r_c;
            Z   <= (r_c == '0);
            N   <= r_c[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu (WIDTH = 32).
module tb_alu;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst;
    logic [3:0]   select;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         Z;
    logic         N;

    int tests_run = 0;
    int tests_failed = 0;

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .select (select),
        .a      (a),
        .b      (b),
        .out    (out),
        .Z      (Z),
        .N      (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operation, wait one edge, then sample just after it.
    task automatic step(input logic [3:0] s, input logic [W-1:0] va, input logic [W-1:0] vb);
        select = s;
        a      = va;
        b      = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
        tests_run++;
        if (out !== 32'h0 || Z !== 1'b1 || N !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: out=%h Z=%b N=%b, required out=00000000 Z=1 N=0", out, Z, N);
        end
        step(4'b0010, 32'h0000_0001, 32'h0);
        tests_run++;
        if (out !== 32'h0 || Z !== 1'b1 || N !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_neg: out=%h Z=%b N=%b, required out=00000000 Z=1 N=0", out, Z, N);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [3:0]   s  [7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0010, 4'b0011, 4'b0000};
        logic [W-1:0] va [7] = '{32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'd6, 32'hFFFF_FFFF};
        logic [W-1:0] vb [7] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd6, 32'd1};
        logic [W-1:0] ex [7] = '{32'd11, 32'd7, 32'd1, 32'd6, 32'hFFFF_FFFA, 32'd0, 32'd0};
        logic         ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic         en [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(s[i], va[i], vb[i]);
            tests_run++;
            if (out !== ex[i] || Z !== ez[i] || N !== en[i]) begin
                tests_failed++;
                $display("FAIL arith[%0d]: out=%h Z=%b N=%b, required out=%h Z=%b N=%b",
                         i, out, Z, N, ex[i], ez[i], en[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0]   s  [3] = '{4'b0001, 4'b0010, 4'b0011};
        logic [W-1:0] va [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        logic [W-1:0] vb [3] = '{32'h1234_5678, 32'h0, 32'h0000_0001};
        logic [W-1:0] ex [3] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF};
        logic         ez [3] = '{1'b1, 1'b0, 1'b0};
        logic         en [3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step(s[i], va[i], vb[i]);
            tests_run++;
            if (out !== ex[i] || Z !== ez[i] || N !== en[i]) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: out=%h Z=%b N=%b, required out=%h Z=%b N=%b",
                         i, out, Z, N, ex[i], ez[i], en[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0]   s  [4] = '{4'b0101, 4'b0110, 4'b0111, 4'b1011};
        logic [W-1:0] ex [4] = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h0FF0_00FF};
        logic         en [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(s[i], 32'hF0F0_1234, 32'h0FF0_00FF);
            tests_run++;
            if (out !== ex[i] || Z !== 1'b0 || N !== en[i]) begin
                tests_failed++;
                $display("FAIL logic[%0d]: out=%h Z=%b N=%b, required out=%h Z=0 N=%b",
                         i, out, Z, N, ex[i], en[i]);
            end
        end
    endtask

    task automatic test_shift_slt();
        logic [3:0]   s  [7] = '{4'b1010, 4'b1001, 4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1100};
        logic [W-1:0] va [7] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h8000_0001,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
        logic [W-1:0] vb [7] = '{32'h0000_0024, 32'h0000_0024, 32'hFFFF_FFE4, 32'h0000_0021,
                                 32'h0, 32'hFFFF_FFFD, 32'h7FFF_FFFF};
        logic [W-1:0] ex [7] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0010, 32'h0000_0002,
                                 32'd1, 32'd0, 32'd1};
        logic         ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic         en [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            step(s[i], va[i], vb[i]);
            tests_run++;
            if (out !== ex[i] || Z !== ez[i] || N !== en[i]) begin
                tests_failed++;
                $display("FAIL shift_slt[%0d]: out=%h Z=%b N=%b, required out=%h Z=%b N=%b",
                         i, out, Z, N, ex[i], ez[i], en[i]);
            end
        end
    endtask

    task automatic test_unknown();
        logic [3:0] s [3] = '{4'b1101, 4'b1110, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            step(s[i], 32'hDEAD_BEEF, 32'h8765_4321);
            tests_run++;
            if (out !== 32'h0 || Z !== 1'b1 || N !== 1'b0) begin
                tests_failed++;
                $display("FAIL unknown_op[%0d]: out=%h Z=%b N=%b, required out=00000000 Z=1 N=0",
                         i, out, Z, N);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   s  [5] = '{4'b0000, 4'b0011, 4'b0100, 4'b0010, 4'b1011};
        logic [W-1:0] va [5] = '{32'd100, 32'd3, 32'h8000_0000, 32'd1, 32'd9};
        logic [W-1:0] vb [5] = '{32'd23, 32'd4, 32'd0, 32'd0, 32'd0};
        logic [W-1:0] ex [5] = '{32'd123, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        logic         ez [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic         en [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(s[i], va[i], vb[i]);
            tests_run++;
            if (out !== ex[i] || Z !== ez[i] || N !== en[i]) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: out=%h Z=%b N=%b, required out=%h Z=%b N=%b",
                         i, out, Z, N, ex[i], ez[i], en[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(4'b0000, 32'd6, 32'd5);
        tests_run++;
        if (out !== 32'd11 || Z !== 1'b0 || N !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: out=%h Z=%b N=%b, required out=0000000b Z=0 N=0", out, Z, N);
        end
        rst = 1'b1;
        step(4'b0000, 32'd6, 32'd5);
        tests_run++;
        if (out !== 32'd0 || Z !== 1'b1 || N !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_hold: out=%h Z=%b N=%b, required out=00000000 Z=1 N=0", out, Z, N);
        end
        rst = 1'b0;
        step(4'b0000, 32'd6, 32'd5);
        tests_run++;
        if (out !== 32'd11 || Z !== 1'b0 || N !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_resume: out=%h Z=%b N=%b, required out=0000000b Z=0 N=0", out, Z, N);
        end
    endtask

    initial begin
        rst    = 1'b1;
        select = 4'b0000;
        a      = '0;
        b      = '0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_wrap();
        test_logic();
        test_shift_slt();
        test_unknown();
        test_back_to_back();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
